// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: the four-master / one-slave-side bus bundle around the arbiter.
//   mN_req_, mN_as_   : per-master request and address strobe (active-low)
//   mN_addr, mN_rw,
//   mN_wr_data        : per-master access fields (rw 1 = read)
//   mN_grnt_          : per-master grant (active-low), driven by the arbiter
//   s_addr, s_as_,
//   s_rw, s_wr_data   : shared slave-side bus, driven by the arbiter
// Modports: master = requesting-master side, slave = arbiter side.
interface bus_arbiter_if #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
);
   logic              m0_req_, m1_req_, m2_req_, m3_req_;
   logic [ADDR_W-1:0] m0_addr, m1_addr, m2_addr, m3_addr;
   logic              m0_as_, m1_as_, m2_as_, m3_as_;
   logic              m0_rw, m1_rw, m2_rw, m3_rw;
   logic [DATA_W-1:0] m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data;
   logic              m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
   logic [ADDR_W-1:0] s_addr;
   logic              s_as_;
   logic              s_rw;
   logic [DATA_W-1:0] s_wr_data;

   modport master (
      output m0_req_, m1_req_, m2_req_, m3_req_,
      output m0_addr, m1_addr, m2_addr, m3_addr,
      output m0_as_, m1_as_, m2_as_, m3_as_,
      output m0_rw, m1_rw, m2_rw, m3_rw,
      output m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data,
      input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
      input  s_addr, s_as_, s_rw, s_wr_data
   );

   modport slave (
      input  m0_req_, m1_req_, m2_req_, m3_req_,
      input  m0_addr, m1_addr, m2_addr, m3_addr,
      input  m0_as_, m1_as_, m2_as_, m3_as_,
      input  m0_rw, m1_rw, m2_rw, m3_rw,
      input  m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data,
      output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
      output s_addr, s_as_, s_rw, s_wr_data
   );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter and master mux for the 4-master shared bus.
//   clk    : bus clock, rising edge
//   reset_ : asynchronous reset, active-low (owner returns to master 0)
//   bus    : bus_arbiter_if.slave - master requests/fields in, grants and
//            shared s_* bus out
//   owner  : current owner index (debug/trace)
// Optional feature macro: BUS_ARB_TIMEOUT_EN - forces a rotation after the
// owner has held the bus TIMEOUT_CYCLES cycles while others were waiting.
module bus_arbiter #(
   parameter int ADDR_W         = 30,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         reset_,
   bus_arbiter_if.slave bus,
   output logic [1:0]   owner
);
   typedef enum logic [1:0] {OWN0, OWN1, OWN2, OWN3} state_t;

   state_t                  state, nxt;
   logic [3:0]              req;      // active-high view of mN_req_
   logic [3:0]              as_n;
   logic [3:0]              rw_v;
   logic [3:0][ADDR_W-1:0]  addr_v;
   logic [3:0][DATA_W-1:0]  data_v;
   logic [3:0]              grnt_n;
   logic                    others;
   logic                    rotate;
   logic                    found;
   logic [1:0]              cand;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("bus_arbiter: TIMEOUT_CYCLES must be >= 1");
   end

   assign req    = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
   assign as_n   = {bus.m3_as_, bus.m2_as_, bus.m1_as_, bus.m0_as_};
   assign rw_v   = {bus.m3_rw, bus.m2_rw, bus.m1_rw, bus.m0_rw};
   assign addr_v = {bus.m3_addr, bus.m2_addr, bus.m1_addr, bus.m0_addr};
   assign data_v = {bus.m3_wr_data, bus.m2_wr_data, bus.m1_wr_data, bus.m0_wr_data};

   // Someone other than the owner is waiting.
   assign others = |(req & ~(4'b0001 << state));

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] hold_cnt;
   logic             expired;

   assign expired = (hold_cnt == CNT_W'(TIMEOUT_CYCLES));
   assign rotate  = !req[state] || (expired && others);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)                        hold_cnt <= '0;
      else if (nxt != state || !others)   hold_cnt <= '0;
      else if (req[state] && !expired)    hold_cnt <= hold_cnt + 1'b1;
   end
`else
   assign rotate = !req[state];
`endif

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) state <= OWN0;
      else         state <= nxt;
   end

   // Search owner+1 .. owner+3, then owner itself; first requester wins.
   // With nobody requesting, ownership is kept so a grant is always out.
   always_comb begin
      nxt   = state;
      found = 1'b0;
      cand  = state;
      if (rotate) begin
         for (int i = 1; i <= 4; i++) begin
            cand = state + 2'(i);
            if (!found && req[cand]) begin
               nxt   = state_t'(cand);
               found = 1'b1;
            end
         end
      end
   end

   // Grants decode the register only, so they move only on an edge or reset.
   assign grnt_n       = ~(4'b0001 << state);
   assign bus.m0_grnt_ = grnt_n[0];
   assign bus.m1_grnt_ = grnt_n[1];
   assign bus.m2_grnt_ = grnt_n[2];
   assign bus.m3_grnt_ = grnt_n[3];

   assign bus.s_addr    = addr_v[state];
   assign bus.s_rw      = rw_v[state];
   assign bus.s_wr_data = data_v[state];
   // Strobe gated by the owner's request so a released owner never strobes.
   assign bus.s_as_     = as_n[state] | ~req[state];
   assign owner         = state;
endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
   logic       clk;
   logic       reset_;
   logic [1:0] owner;
   int         checks = 0;
   int         errors = 0;

   bus_arbiter_if #(.ADDR_W(30), .DATA_W(32)) bus ();

   bus_arbiter #(.ADDR_W(30), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset_(reset_), .bus(bus), .owner(owner)
   );

   wire [3:0] gnt = {bus.m3_grnt_, bus.m2_grnt_, bus.m1_grnt_, bus.m0_grnt_};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_ = 1'b1;
      #3 reset_ = 1'b0;
      #1;
      checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", owner); end
      checks++; if (gnt !== 4'b1110) begin errors++; $display("FAIL reset_gnt got %b exp 1110", gnt); end
      checks++; if (bus.s_addr !== 30'h0000_0100) begin errors++; $display("FAIL reset_saddr got %h exp 100", bus.s_addr); end
      checks++; if (bus.s_as_ !== 1'b1) begin errors++; $display("FAIL reset_sas got %b exp 1", bus.s_as_); end
      step();
      reset_ = 1'b1;
      bus.m2_req_ = 1'b0;
      step();
      checks++; if (owner !== 2'd2) begin errors++; $display("FAIL pre_reset_owner got %0d exp 2", owner); end
      #2 reset_ = 1'b0;
      #1;
      checks++; if (owner !== 2'd0) begin errors++; $display("FAIL midreset_owner got %0d exp 0", owner); end
      checks++; if (gnt !== 4'b1110) begin errors++; $display("FAIL midreset_gnt got %b exp 1110", gnt); end
      step();
      reset_ = 1'b1;
      bus.m2_req_ = 1'b1;
   endtask

   task automatic test_single();
      bus.m2_addr    = 30'h0000_1234;
      bus.m2_rw      = 1'b0;
      bus.m2_wr_data = 32'hCAFE_0002;
      bus.m2_req_    = 1'b0;
      bus.m0_as_     = 1'b0;   // owner strobes while not requesting
      #1;
      checks++; if (bus.s_as_ !== 1'b1) begin errors++; $display("FAIL single_gated_as got %b exp 1", bus.s_as_); end
      step();
      checks++; if (gnt !== 4'b1011) begin errors++; $display("FAIL single_gnt got %b exp 1011", gnt); end
      checks++; if (bus.s_addr !== 30'h0000_1234) begin errors++; $display("FAIL single_saddr got %h exp 1234", bus.s_addr); end
      checks++; if (bus.s_rw !== 1'b0) begin errors++; $display("FAIL single_srw got %b exp 0", bus.s_rw); end
      checks++; if (bus.s_wr_data !== 32'hCAFE_0002) begin errors++; $display("FAIL single_sdata got %h exp cafe0002", bus.s_wr_data); end
      checks++; if (bus.s_as_ !== 1'b1) begin errors++; $display("FAIL single_nonowner_as got %b exp 1", bus.s_as_); end
      bus.m2_as_ = 1'b0;
      #1;
      checks++; if (bus.s_as_ !== 1'b0) begin errors++; $display("FAIL single_sas got %b exp 0", bus.s_as_); end
      bus.m2_as_ = 1'b1;
      bus.m0_as_ = 1'b1;
   endtask

   task automatic test_rotation();
      bus.m2_req_ = 1'b1;
      bus.m1_req_ = 1'b0;
      step();
      checks++; if (owner !== 2'd1 || gnt !== 4'b1101) begin errors++; $display("FAIL rot_to1 got %0d/%b exp 1/1101", owner, gnt); end
      bus.m1_req_ = 1'b1;
      bus.m0_req_ = 1'b0;
      bus.m3_req_ = 1'b0;
      step();
      checks++; if (owner !== 2'd3) begin errors++; $display("FAIL rot_to3 got %0d exp 3", owner); end
      checks++; if (bus.s_addr !== 30'h0000_0103) begin errors++; $display("FAIL rot_saddr3 got %h exp 103", bus.s_addr); end
      bus.m3_req_ = 1'b1;
      step();
      checks++; if (owner !== 2'd0) begin errors++; $display("FAIL rot_to0 got %0d exp 0", owner); end
   endtask

   task automatic test_idle_hold();
      bus.m0_req_ = 1'b1;
      bus.m3_req_ = 1'b0;
      step();
      checks++; if (owner !== 2'd3) begin errors++; $display("FAIL idle_setup got %0d exp 3", owner); end
      bus.m3_req_ = 1'b1;
      bus.m3_as_  = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         checks++; if (owner !== 2'd3) begin errors++; $display("FAIL idle_owner cyc %0d got %0d exp 3", c, owner); end
      end
      checks++; if (gnt !== 4'b0111) begin errors++; $display("FAIL idle_gnt got %b exp 0111", gnt); end
      checks++; if (bus.s_as_ !== 1'b1) begin errors++; $display("FAIL idle_sas got %b exp 1", bus.s_as_); end
      bus.m3_as_ = 1'b1;
   endtask

   task automatic test_rerequest();
      bus.m0_req_ = 1'b0;
      step();
      checks++; if (owner !== 2'd0) begin errors++; $display("FAIL rereq_setup got %0d exp 0", owner); end
      bus.m0_req_ = 1'b1;
      bus.m1_req_ = 1'b0;
      step();
      bus.m0_req_ = 1'b0;
      #1;
      checks++; if (owner !== 2'd1) begin errors++; $display("FAIL rereq_owner got %0d exp 1", owner); end
      step();
      checks++; if (owner !== 2'd1) begin errors++; $display("FAIL rereq_hold got %0d exp 1", owner); end
   endtask

   task automatic test_timeout();
      bus.m1_req_ = 1'b1;
      step();
      checks++; if (owner !== 2'd0) begin errors++; $display("FAIL to_setup got %0d exp 0", owner); end
      bus.m1_req_ = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      for (int e = 1; e <= 5; e++) begin
         step();
         checks++;
         if (owner !== ((e == 5) ? 2'd1 : 2'd0)) begin
            errors++; $display("FAIL timeout edge %0d got %0d exp %0d", e, owner, (e == 5) ? 1 : 0);
         end
      end
`else
      for (int e = 1; e <= 100; e++) begin
         step();
         checks++; if (owner !== 2'd0) begin errors++; $display("FAIL no_timeout edge %0d got %0d exp 0", e, owner); end
      end
`endif
   endtask

   initial begin
      bus.m0_req_ = 1'b1; bus.m1_req_ = 1'b1; bus.m2_req_ = 1'b1; bus.m3_req_ = 1'b1;
      bus.m0_as_  = 1'b1; bus.m1_as_  = 1'b1; bus.m2_as_  = 1'b1; bus.m3_as_  = 1'b1;
      bus.m0_rw   = 1'b1; bus.m1_rw   = 1'b1; bus.m2_rw   = 1'b1; bus.m3_rw   = 1'b1;
      bus.m0_addr = 30'h100; bus.m1_addr = 30'h101; bus.m2_addr = 30'h102; bus.m3_addr = 30'h103;
      bus.m0_wr_data = 32'hD0; bus.m1_wr_data = 32'hD1; bus.m2_wr_data = 32'hD2; bus.m3_wr_data = 32'hD3;
      reset_ = 1'b1;
      test_reset();
      test_single();
      test_rotation();
      test_idle_hold();
      test_rerequest();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and master multiplexer for the four-master / eight-slave shared bus. Selects one bus owner among masters 0–3 and returns active-low grants. Routes the owner's address, strobe, read/write and write data onto the shared slave-side bus. `s_addr` feeds the bus address decoder that generates the slave chip selects, so this block sits directly upstream of it.

## Interface
**Parameters**
- `ADDR_W`, 30 — word address width. Must match the decoder's `s_addr` width.
- `DATA_W`, 32 — write data width.
- `TIMEOUT_CYCLES`, 255 — forced-release threshold. Used only with `BUS_ARB_TIMEOUT_EN`.

**Ports**
- `clk` input 1 — bus clock. All state changes on the rising edge.
- `reset_` input 1 — asynchronous reset, active-low.
- `m0_req_`..`m3_req_` input 1 each — bus request from master n, active-low.
- `m0_addr`..`m3_addr` input `ADDR_W` each — address from master n.
- `m0_as_`..`m3_as_` input 1 each — address strobe from master n, active-low.
- `m0_rw`..`m3_rw` input 1 each — read/write from master n: 1 = read, 0 = write.
- `m0_wr_data`..`m3_wr_data` input `DATA_W` each — write data from master n.
- `m0_grnt_`..`m3_grnt_` output 1 each — bus grant to master n, active-low.
- `s_addr` output `ADDR_W` — shared address, driven to the address decoder.
- `s_as_` output 1 — shared address strobe, active-low.
- `s_rw` output 1 — shared read/write.
- `s_wr_data` output `DATA_W` — shared write data.
- `owner` output 2 — index of the current owner. Debug and trace only.

## Operation
- **State.** A 2-bit `owner` register, one FSM state per master: OWN0..OWN3.
- **Grants.** Combinational decode of `owner`. Exactly one `mN_grnt_` is low at all times, including when no master requests.
- **Hold rule.** While the owner's `req_` is low, `owner` is unchanged.
- **Release rule.** When the owner's `req_` is high, the arbiter searches owner+1, owner+2, owner+3, owner+0 (mod 4). The first master with `req_` low becomes `owner` at the next edge. If no master requests, `owner` holds.
- **Simultaneous requests.** Resolved only by the rotation order above. There is no fixed priority.
- **Mux.**
  - `s_addr`, `s_rw` and `s_wr_data` follow the owner's inputs combinationally.
  - `s_as_ = mO_as_ | mO_req_`, where O is the owner. The strobe is forced high if the owner is not requesting, so the decoder never sees a stale access.
- **Non-owners.** Their `as_` is ignored.

## Timing
- **Reset (async, `reset_` low).**
  - `owner` = 0, so `m0_grnt_` = 0 and `m1_grnt_`..`m3_grnt_` = 1.
  - `s_*` reflect master 0's inputs, with `s_as_` gated as above.
  - The timeout counter (if present) = 0.
  - Reset asserted mid-transfer aborts ownership immediately, with no edge needed.
- **Handoff latency.**
  - Owner `req_` rises in cycle k; the new `owner` is registered at the edge ending cycle k; the new grant is visible in cycle k+1.
  - There is no idle cycle between owners when a requester is waiting.
- **Re-request.** An owner that releases and re-requests in the same cycle loses the bus if any other master is requesting.
- **Grant glitches.** Grants change only after a clock edge or on async reset. They never change mid-cycle.
- **Mux delay.** Output mux paths are purely combinational, with zero cycles from master inputs to `s_*`.

## Configuration
- **`BUS_ARB_TIMEOUT_EN` defined:**
  - Adds a hold counter of width clog2(`TIMEOUT_CYCLES`+1).
  - It increments each cycle the owner holds the bus while at least one other master requests. It saturates at `TIMEOUT_CYCLES` and clears on any `owner` change or when no other master requests.
  - When the counter equals `TIMEOUT_CYCLES` and another master requests, the next edge rotates `owner` exactly as if the owner had released.
- **`BUS_ARB_TIMEOUT_EN` undefined:**
  - No counter and no `TIMEOUT_CYCLES` logic.
  - An owner holds the bus indefinitely while its `req_` is low.

## Test plan
- **Reset.** Assert `reset_`=0 mid-cycle with `owner`=2 -> immediately `owner`=0, `m0_grnt_`=0, other grants 1.
- **Single request.** From `owner`=0 with `m0_req_`=1, drive `m2_req_`=0 and `m2_addr`=30'h0000_1234 -> after one edge `m2_grnt_`=0 and `s_addr`=30'h0000_1234. Asserting `m2_as_`=0 then gives `s_as_`=0.
- **Rotation.** `owner`=1, `m1_req_` goes high, `m0_req_`=`m3_req_`=0 -> next `owner`=3. When m3 releases, next `owner`=0.
- **Idle hold.** All `req_`=1 for 10 cycles with `owner`=3 -> `owner` stays 3, `m3_grnt_`=0, `s_as_`=1 even with `m3_as_`=0.
- **Re-request.** `owner`=0 drops and re-asserts `m0_req_` in one cycle with `m1_req_`=0 -> `owner`=1.
- **Timeout (with `BUS_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4).** m0 holds, m1 requests continuously -> `owner` changes to 1 after exactly 5 edges from m1's request. Without the macro, `owner` stays 0 for at least 100 cycles.
